int_event_capture: RTL and testbench
====================================

# int_event_capture

Source-side companion to the 32-bit interrupt controller: captures raw peripheral event lines into sticky `IntStatus` bits and clears them on the controller's `IntReset` pulses. It sits between peripherals and the controller's `IntStatus`/`IntReset` ports and exposes a 16-bit register window on the same bus (`Addr`/`En`/`Rd`/`Wr`). Software uses it to select per-source polarity and edge/level mode, and to read and clear overflow (missed-event) flags.

## Interface
- `POL_RESET`, default 32'h0000_0000: reset value of the polarity register.
- `Clk` in 1: system clock; all logic on its rising edge.
- `Reset` in 1: reset, synchronous, active-high; clock `Clk`.
- `Addr` in 3: register word select.
- `DataRd` out 16: read data, combinational from `Addr`.
- `DataWr` in 16: write data.
- `En` in 1: block select.
- `Rd` in 1: read strobe, unused internally; reads have no side effects.
- `Wr` in 1: write strobe; write occurs on a `Clk` edge with `Wr & En`.
- `Event` in 32: raw peripheral event lines.
- `IntStatus` out 32: sticky status, registered, to controller.
- `IntReset` in 32: per-bit clear from controller, active-high.

## Operation
- Sample path: `s[i]` = synchronized `Event[i]` (see Configuration). `s_d[i]` = `s[i]` delayed one cycle.
- Synchronizer flops and `s_d` are not reset. They sample continuously, including during `Reset`.
- Effective level: `e = s ^ Pol`, `e_d = s_d ^ Pol`. Both use the current `Pol`, so a polarity write never creates an edge.
- `Pol` bit: 0 = active-high/rising, 1 = active-low/falling.
- `Mode` bit: 0 = edge, 1 = level.
- `set[i]` is `e[i] & ~e_d[i]` in edge mode and `e[i]` in level mode.
- `IntStatus[i] <= set[i] | (IntStatus[i] & ~IntReset[i])`. Set wins over a simultaneous clear.
- Overflow, edge mode only: `Ovf[i] <= 1` when `set[i] & IntStatus[i] & ~IntReset[i]`.
- Register map, write/read:
  - 0: `Pol[15:0]` RW
  - 1: `Pol[31:16]` RW
  - 2: `Mode[15:0]` RW
  - 3: `Mode[31:16]` RW
  - 4: `Ovf[15:0]` read, write-1-to-clear
  - 5: `Ovf[31:16]` read, write-1-to-clear
  - 6: `IntStatus[15:0]` RO
  - 7: `IntStatus[31:16]` RO
- Writes to 6/7 are ignored.
- A W1C write coinciding with a new overflow leaves that `Ovf` bit at 1.
- While `Reset` is high: `IntStatus`, `Ovf` and `Mode` load 0, and `Pol` loads `POL_RESET`.

## Timing
- Reset values: `IntStatus` = 0, `Ovf` = 0, `Mode` = 0, `Pol` = `POL_RESET`.
- `DataRd` follows `Addr` combinationally and reflects register values after the edge.
- Event latency with sync: `Event` rises before edge e1 → `IntStatus` high after e3.
- Event latency without sync: → `IntStatus` high after e1.
- Clear latency: `IntReset[i]` high at edge n → `IntStatus[i]` low after n, unless set at n.
- Spurious events after reset:
  - No spurious event if `Reset` is held at least 3 cycles with a stable `Event`.
  - Only one cycle of `Reset` may yield one capture of a pre-existing level.
- Level mode: `IntStatus` remains 1 while the source is active. `IntReset` takes effect only after the source deasserts.
- A one-cycle `Event` pulse is guaranteed captured only without sync. With sync, `Event` must be held at least 2 `Clk` cycles.

## Configuration
- Macro: `INT_EVENT_CAPTURE_SYNC_EN`.
- Defined:
  - Two-flop synchronizer per bit, so `s` is the second flop.
  - For asynchronous sources.
  - Latency 3.
- Undefined:
  - `s` = `Event` directly.
  - Sources must be `Clk`-synchronous.
  - Latency 1.

## Structure
- Package `int_event_pkg`:
  - Address constants `ADDR_POL_LO` … `ADDR_STAT_HI`.
  - `NUM_SRC` = 32.
  - Mode/polarity encodings.
- Sub-module `int_event_bit`:
  - Per-source synchronizer, `s_d`, `set` logic, status and overflow flops.
  - Instantiated 32× via generate.
- Top level holds `Pol`/`Mode` registers, write decode and the read mux.

## Test plan
- Reset with `Event`=32'h0000_00FF held ≥3 cycles → `IntStatus`=0, `Ovf`=0. Read addr 0 → `POL_RESET[15:0]`.
- `Event[3]` 0→1 (sync on) → `IntStatus`=32'h8 after 3rd edge. `IntReset`=32'h8 for 1 cycle → `IntStatus`=0 next edge.
- Write addr 1 = 16'h0001, then pulse `Event[16]` 1→0 → `IntStatus[16]`=1. The polarity write alone sets nothing.
- Two rising edges on bit 5 without a clear → `Ovf[5]`=1, addr 4 reads 16'h0020. Write addr 4 = 16'h0020 → reads 0.
- `IntReset[2]` asserted in the same cycle as a new `set[2]` → `IntStatus[2]` stays 1, `Ovf[2]` stays 0.
- Write addr 2 = 16'h0001, hold `Event[0]`=1, pulse `IntReset[0]` → `IntStatus[0]` stays 1. Drop `Event[0]`, pulse `IntReset[0]` → 0.

Source files
------------

// File: rtl/int_event_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_event_pkg                                                              |
// | Shared constants for the interrupt event capture block.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package int_event_pkg;

  localparam int NUM_SRC = 32;

  localparam logic [2:0] ADDR_POL_LO  = 3'd0;
  localparam logic [2:0] ADDR_POL_HI  = 3'd1;
  localparam logic [2:0] ADDR_MODE_LO = 3'd2;
  localparam logic [2:0] ADDR_MODE_HI = 3'd3;
  localparam logic [2:0] ADDR_OVF_LO  = 3'd4;
  localparam logic [2:0] ADDR_OVF_HI  = 3'd5;
  localparam logic [2:0] ADDR_STAT_LO = 3'd6;
  localparam logic [2:0] ADDR_STAT_HI = 3'd7;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;
  localparam logic POL_HIGH   = 1'b0;
  localparam logic POL_LOW    = 1'b1;

  typedef logic [NUM_SRC-1:0] src_vec_t;

endpackage
`default_nettype wire

// File: rtl/int_event_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_event_bit                                                              |
// | One event source: optional synchronizer, edge/level detect, sticky status  |
// | and overflow flag. Synchronizer enabled by INT_EVENT_CAPTURE_SYNC_EN.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module int_event_bit
  import int_event_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic evt,
  input  logic pol,
  input  logic mode,
  input  logic int_reset,
  input  logic ovf_clr,
  output logic status,
  output logic ovf
);

  logic s;
  logic s_d;
  logic e;
  logic e_d;
  logic set;

`ifdef INT_EVENT_CAPTURE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Sample path is deliberately unreset so it settles while Reset is held.
  always_ff @(posedge Clk) begin
    sync_q1 <= evt;
    sync_q2 <= sync_q1;
  end

  assign s = sync_q2;
`else
  assign s = evt;
`endif

  always_ff @(posedge Clk) begin
    s_d <= s;
  end

  // Both taps use the current polarity, so a polarity change is never an edge.
  assign e   = s ^ pol;
  assign e_d = s_d ^ pol;
  assign set = (mode == MODE_LEVEL) ? e : (e & ~e_d);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      status <= set | (status & ~int_reset);
      if ((mode == MODE_EDGE) && set && status && !int_reset)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_event_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_event_capture                                                          |
// | Captures peripheral events into sticky IntStatus bits with a 16-bit        |
// | register window. Optional synchronizer: INT_EVENT_CAPTURE_SYNC_EN.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module int_event_capture
  import int_event_pkg::*;
#(
  parameter logic [31:0] POL_RESET = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [31:0] Event,
  output logic [31:0] IntStatus,
  input  logic [31:0] IntReset
);

  src_vec_t pol;
  src_vec_t mode;
  src_vec_t ovf;
  src_vec_t ovf_clr;
  src_vec_t status;
  logic     wr_en;
  logic     unused_rd;

  assign wr_en     = Wr & En;
  assign unused_rd = Rd;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pol  <= POL_RESET;
      mode <= '0;
    end else if (wr_en) begin
      case (Addr)
        ADDR_POL_LO:  pol[15:0]   <= DataWr;
        ADDR_POL_HI:  pol[31:16]  <= DataWr;
        ADDR_MODE_LO: mode[15:0]  <= DataWr;
        ADDR_MODE_HI: mode[31:16] <= DataWr;
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf_clr = '0;
    if (wr_en && (Addr == ADDR_OVF_LO)) ovf_clr[15:0]  = DataWr;
    if (wr_en && (Addr == ADDR_OVF_HI)) ovf_clr[31:16] = DataWr;
  end

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      int_event_bit u_bit (
        .Clk       (Clk),
        .Reset     (Reset),
        .evt       (Event[i]),
        .pol       (pol[i]),
        .mode      (mode[i]),
        .int_reset (IntReset[i]),
        .ovf_clr   (ovf_clr[i]),
        .status    (status[i]),
        .ovf       (ovf[i])
      );
    end
  endgenerate

  assign IntStatus = status;

  always_comb begin
    DataRd = '0;
    case (Addr)
      ADDR_POL_LO:  DataRd = pol[15:0];
      ADDR_POL_HI:  DataRd = pol[31:16];
      ADDR_MODE_LO: DataRd = mode[15:0];
      ADDR_MODE_HI: DataRd = mode[31:16];
      ADDR_OVF_LO:  DataRd = ovf[15:0];
      ADDR_OVF_HI:  DataRd = ovf[31:16];
      ADDR_STAT_LO: DataRd = status[15:0];
      ADDR_STAT_HI: DataRd = status[31:16];
      default:      DataRd = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_int_event_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_int_event_capture                                                       |
// | Directed scenarios plus randomized traffic against an event-history model. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_int_event_capture;

  localparam logic [31:0] POL_RST = 32'h8000_0000;
`ifdef INT_EVENT_CAPTURE_SYNC_EN
  localparam int LAT  = 3;
  localparam int SDLY = 2;
`else
  localparam int LAT  = 1;
  localparam int SDLY = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  Addr = 3'd0;
  logic [15:0] DataRd;
  logic [15:0] DataWr = 16'h0;
  logic        En = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [31:0] Event = 32'h0000_00FF;
  logic [31:0] IntStatus;
  logic [31:0] IntReset = 32'h0;

  int checks = 0;
  int errors = 0;

  // Model: hist[k] is Event as sampled k edges ago; sticky state as plain vectors.
  logic [31:0] hist [4];
  logic [31:0] m_pol, m_mode, m_ovf, m_stat;

  int_event_capture #(.POL_RESET(POL_RST)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Addr      (Addr),
    .DataRd    (DataRd),
    .DataWr    (DataWr),
    .En        (En),
    .Rd        (Rd),
    .Wr        (Wr),
    .Event     (Event),
    .IntStatus (IntStatus),
    .IntReset  (IntReset)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_pol[15:0];
      3'd1:    return m_pol[31:16];
      3'd2:    return m_mode[15:0];
      3'd3:    return m_mode[31:16];
      3'd4:    return m_ovf[15:0];
      3'd5:    return m_ovf[31:16];
      3'd6:    return m_stat[15:0];
      default: return m_stat[31:16];
    endcase
  endfunction

  task automatic tick();
    logic [31:0] ev, ir, s, sd, nstat, novf, clr;
    logic        rst, we, act, was_act, fire;
    logic [2:0]  a;
    logic [15:0] wd;
    ev = Event; ir = IntReset; rst = Reset; we = Wr && En; a = Addr; wd = DataWr;
    @(posedge Clk);
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ev;
    s  = hist[SDLY];
    sd = hist[SDLY+1];
    if (rst) begin
      m_stat = '0; m_ovf = '0; m_mode = '0; m_pol = POL_RST;
    end else begin
      clr = '0;
      if (we && a == 3'd4) clr[15:0]  = wd;
      if (we && a == 3'd5) clr[31:16] = wd;
      for (int i = 0; i < 32; i++) begin
        act     = (s[i] != m_pol[i]);
        was_act = (sd[i] != m_pol[i]);
        fire    = m_mode[i] ? act : (act && !was_act);
        nstat[i] = fire || (m_stat[i] && !ir[i]);
        novf[i]  = (fire && !m_mode[i] && m_stat[i] && !ir[i]) ? 1'b1 : (m_ovf[i] && !clr[i]);
      end
      m_stat = nstat;
      m_ovf  = novf;
      if (we) begin
        case (a)
          3'd0: m_pol[15:0]   = wd;
          3'd1: m_pol[31:16]  = wd;
          3'd2: m_mode[15:0]  = wd;
          3'd3: m_mode[31:16] = wd;
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    tick();
    Wr = 1'b0; En = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Event = 32'h0000_00FF; Addr = 3'd4;
    repeat (4) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", IntStatus, 32'h0); end
    checks++;
    if (DataRd !== 16'h0) begin errors++; $display("FAIL reset_ovf: got %h expected %h", DataRd, 16'h0); end
    Reset = 1'b0; Addr = 3'd0;
    tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL reset_no_spurious: got %h expected %h", IntStatus, 32'h0); end
    checks++;
    if (DataRd !== POL_RST[15:0]) begin errors++; $display("FAIL reset_pol_lo: got %h expected %h", DataRd, POL_RST[15:0]); end
    Addr = 3'd1; #1;
    checks++;
    if (DataRd !== POL_RST[31:16]) begin errors++; $display("FAIL reset_pol_hi: got %h expected %h", DataRd, POL_RST[31:16]); end
    Addr = 3'd2; #1;
    checks++;
    if (DataRd !== 16'h0) begin errors++; $display("FAIL reset_mode: got %h expected %h", DataRd, 16'h0); end
    Event = 32'h0;
    repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL falling_ignored: got %h expected %h", IntStatus, 32'h0); end
  endtask

  task automatic test_edge_clear();
    Event[3] = 1'b1;
    repeat (LAT - 1) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL edge_early: got %h expected %h", IntStatus, 32'h0); end
    tick();
    checks++;
    if (IntStatus !== 32'h8) begin errors++; $display("FAIL edge_capture: got %h expected %h", IntStatus, 32'h8); end
    IntReset = 32'h8; tick(); IntReset = 32'h0;
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL edge_clear: got %h expected %h", IntStatus, 32'h0); end
    Event[3] = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_polarity();
    wr(3'd1, 16'h0001);
    Addr = 3'd1; #1;
    checks++;
    if (DataRd !== 16'h0001) begin errors++; $display("FAIL pol_readback: got %h expected %h", DataRd, 16'h0001); end
    repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL pol_write_no_edge: got %h expected %h", IntStatus, 32'h0); end
    Event[16] = 1'b1;
    repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL pol_rise_ignored: got %h expected %h", IntStatus, 32'h0); end
    Event[16] = 1'b0;
    repeat (LAT) tick();
    checks++;
    if (IntStatus !== 32'h0001_0000) begin errors++; $display("FAIL pol_fall_capture: got %h expected %h", IntStatus, 32'h0001_0000); end
    IntReset = 32'h0001_0000; tick(); IntReset = 32'h0;
  endtask

  task automatic test_overflow();
    Event[5] = 1'b1; repeat (LAT + 1) tick();
    Event[5] = 1'b0; repeat (2) tick();
    Event[5] = 1'b1; repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h20) begin errors++; $display("FAIL ovf_status: got %h expected %h", IntStatus, 32'h20); end
    Addr = 3'd4; #1;
    checks++;
    if (DataRd !== 16'h0020) begin errors++; $display("FAIL ovf_set: got %h expected %h", DataRd, 16'h0020); end
    wr(3'd4, 16'h0020);
    Addr = 3'd4; #1;
    checks++;
    if (DataRd !== 16'h0) begin errors++; $display("FAIL ovf_w1c: got %h expected %h", DataRd, 16'h0); end
    IntReset = 32'h20; Event[5] = 1'b0; tick(); IntReset = 32'h0;
    repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL ovf_cleanup: got %h expected %h", IntStatus, 32'h0); end
  endtask

  task automatic test_set_wins();
    Event[2] = 1'b1; repeat (LAT + 1) tick();
    Event[2] = 1'b0; repeat (2) tick();
    Event[2] = 1'b1; repeat (LAT - 1) tick();
    IntReset = 32'h4; tick(); IntReset = 32'h0;
    checks++;
    if (IntStatus !== 32'h4) begin errors++; $display("FAIL set_wins_status: got %h expected %h", IntStatus, 32'h4); end
    Addr = 3'd4; #1;
    checks++;
    if (DataRd !== 16'h0) begin errors++; $display("FAIL set_wins_no_ovf: got %h expected %h", DataRd, 16'h0); end
    IntReset = 32'h4; Event[2] = 1'b0; tick(); IntReset = 32'h0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_level();
    wr(3'd2, 16'h0001);
    Event[0] = 1'b1; repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h1) begin errors++; $display("FAIL level_capture: got %h expected %h", IntStatus, 32'h1); end
    IntReset = 32'h1; tick(); IntReset = 32'h0;
    checks++;
    if (IntStatus !== 32'h1) begin errors++; $display("FAIL level_clear_blocked: got %h expected %h", IntStatus, 32'h1); end
    Event[0] = 1'b0; repeat (LAT + 1) tick();
    checks++;
    if (IntStatus !== 32'h1) begin errors++; $display("FAIL level_sticky: got %h expected %h", IntStatus, 32'h1); end
    IntReset = 32'h1; tick(); IntReset = 32'h0;
    checks++;
    if (IntStatus !== 32'h0) begin errors++; $display("FAIL level_clear: got %h expected %h", IntStatus, 32'h0); end
    wr(3'd2, 16'h0000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      Event    = Event ^ ($urandom & $urandom & $urandom);
      IntReset = $urandom & $urandom & $urandom;
      Addr     = 3'($urandom_range(0, 7));
      DataWr   = 16'($urandom);
      Rd       = 1'($urandom);
      Wr       = ($urandom_range(0, 5) == 0);
      En       = Wr ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      Reset    = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (IntStatus !== m_stat) begin errors++; $display("FAIL rand_status n=%0d: got %h expected %h", n, IntStatus, m_stat); end
      checks++;
      if (DataRd !== m_read(Addr)) begin errors++; $display("FAIL rand_read n=%0d addr=%0d: got %h expected %h", n, Addr, DataRd, m_read(Addr)); end
    end
    Wr = 1'b0; En = 1'b0; Reset = 1'b0; IntReset = 32'h0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) hist[k] = 32'h0000_00FF;
    m_pol = POL_RST; m_mode = '0; m_ovf = '0; m_stat = '0;
    test_reset();
    test_edge_clear();
    test_polarity();
    test_overflow();
    test_set_wins();
    test_level();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
